// File: rtl/lwmac_regmap_pkg.sv
// Register-window constants, offset decode helper and FSM encoding shared by
// the lwmac register-file arbiter and its bench-visible decode.
package lwmac_regmap_pkg;

  localparam logic [31:0] BASE_ADDR = 32'hFFFFFA40;
  localparam logic [31:0] WIN_SIZE  = 32'd32;

  localparam logic [4:0] RSVD_LO = 5'h02;
  localparam logic [4:0] RSVD_HI = 5'h11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic off_valid(input logic [4:0] off);
    return (off < RSVD_LO) || (off > RSVD_HI);
  endfunction

endpackage

// File: rtl/lwmac_regfile_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: on a tie the requester not granted last wins.
// Grant is combinational; the last-grant pointer moves only when i_upd is high.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);

  logic r_last;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_last <= 1'b1;
    else if (i_upd && (|i_req)) r_last <= o_gnt[1];
  end

endmodule

// File: rtl/lwmac_regfile_arbiter.sv
// Two-master front end for the lwmac 32x32 register file: window decode,
// round-robin grant, one register access per transaction (IDLE/ACCESS/RESP).
module lwmac_regfile_arbiter #(
  parameter logic [31:0] BASE_ADDR = lwmac_regmap_pkg::BASE_ADDR,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              write,
  output logic [31:0]       wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic [31:0]       rdAddrA,
  input  logic [DATA_W-1:0] rdDataA
);

  import lwmac_regmap_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sel;
  logic              r_we;
  logic              r_ok;
  logic [4:0]        r_off;
  logic [4:0]        r_rd_off;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_arb_en;
  logic              w_win;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_win;
  logic [4:0]        w_off;
  logic              w_ok;

  assign w_req    = {req1, req0};
  assign w_arb_en = (r_state == ST_IDLE) && (|w_gnt);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .i_upd (w_arb_en),
    .o_gnt (w_gnt)
  );

  assign w_win   = w_gnt[1];
  assign w_we    = w_win ? we1    : we0;
  assign w_addr  = w_win ? addr1  : addr0;
  assign w_wdata = w_win ? wdata1 : wdata0;

  // Explicit bounds compare: a plain subtraction would let wrapped addresses alias in.
  assign w_in_win = (w_addr >= BASE_ADDR) && (w_addr <= (BASE_ADDR + WIN_SIZE - 32'd1));
  assign w_off    = w_addr[4:0] - BASE_ADDR[4:0];
  assign w_ok     = w_in_win && off_valid(w_off);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_ok     <= 1'b0;
      r_off    <= '0;
      r_rd_off <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arb_en) begin
        r_sel   <= w_win;
        r_we    <= w_we;
        r_ok    <= w_ok;
        r_off   <= w_off;
        r_wdata <= w_wdata;
        if (w_ok && !w_we) r_rd_off <= w_off;
      end
      if (r_state == ST_ACCESS) r_rdata <= (!r_we && r_ok) ? rdDataA : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (|w_req) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    write   = (r_state == ST_ACCESS) && r_we && r_ok;
    wrAddr  = {27'd0, r_off};
    wrData  = r_wdata;
    rdAddrA = {27'd0, r_rd_off};
    ack0    = (r_state == ST_RESP) && !r_sel;
    ack1    = (r_state == ST_RESP) &&  r_sel;
    err0    = ack0 && !r_ok;
    err1    = ack1 && !r_ok;
    rdata0  = ack0 ? r_rdata : '0;
    rdata1  = ack1 ? r_rdata : '0;
  end

endmodule

// File: tb/tb_lwmac_regfile_arbiter.sv
// Scenario bench for lwmac_regfile_arbiter with a behavioural register file
// and an in-order expected-response queue.
module tb_lwmac_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        write;
  logic [31:0] wrAddr, wrData, rdAddrA, rdDataA;

  always #5 clk = ~clk;

  lwmac_regfile_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddrA(rdAddrA), .rdDataA(rdDataA)
  );

  // Behavioural register file
  logic [31:0] mem [32];
  int          wr_count = 0;
  int          cyc = 0;

  assign rdDataA = mem[rdAddrA[4:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (write) begin
      mem[wrAddr[4:0]] <= wrData;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] shadow [32];
  int          checks = 0;
  int          errors = 0;
  int          tb_last = 1;

  function automatic exp_t mk(input int id, input logic err, input logic [31:0] rd);
    exp_t e;
    e.id = id; e.err = err; e.rdata = rd;
    return e;
  endfunction

  task automatic drive(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else         begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
  endtask

  // Waits for the next ack and reports what was seen; releases the acked req.
  task automatic wait_ack(input int budget, output int id, output logic err,
                          output logic [31:0] rd, output int at_cyc, output bit to);
    to = 1'b1; id = -1; err = 1'bx; rd = 'x; at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        id     = ack1 ? 1 : 0;
        err    = ack1 ? err1 : err0;
        rd     = ack1 ? rdata1 : rdata0;
        at_cyc = cyc;
        to     = 1'b0;
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [164:0] outs;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    outs = {ack0, ack1, err0, err1, rdata0, rdata1, write, wrAddr, wrData, rdAddrA};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int id, at, c0, w0; logic err; logic [31:0] rd; bit to; exp_t e;
    w0 = wr_count;
    c0 = cyc;
    drive(0, 1'b1, 32'hFFFFFA41, 32'hDEADBEEF);
    q.push_back(mk(0, 1'b0, 32'h0));
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || wrAddr !== 32'd1 || wrData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_access got write=%b wrAddr=%h wrData=%h want 1/1/deadbeef", write, wrAddr, wrData);
    end
    wait_ack(4, id, err, rd, at, to);
    e = q.pop_front();
    checks++;
    if (to || id != e.id || err !== e.err || rd !== e.rdata || at != c0 + 2) begin
      errors++;
      $display("FAIL write_ack got to=%0b id=%0d err=%b rd=%h cyc=%0d want id=%0d err=%b rd=%h cyc=%0d",
               to, id, err, rd, at, e.id, e.err, e.rdata, c0 + 2);
    end
    checks++;
    if (wr_count - w0 != 1) begin
      errors++;
      $display("FAIL write_count got %0d want 1", wr_count - w0);
    end
    tb_last = 0;
    @(negedge clk);
    c0 = cyc;
    drive(0, 1'b0, 32'hFFFFFA41, 32'h0);
    q.push_back(mk(0, 1'b0, 32'hDEADBEEF));
    wait_ack(6, id, err, rd, at, to);
    e = q.pop_front();
    checks++;
    if (to || id != e.id || err !== e.err || rd !== e.rdata || at != c0 + 2) begin
      errors++;
      $display("FAIL readback got to=%0b id=%0d err=%b rd=%h cyc=%0d want id=%0d err=%b rd=%h cyc=%0d",
               to, id, err, rd, at, e.id, e.err, e.rdata, c0 + 2);
    end
    tb_last = 0;
  endtask

  task automatic test_tie;
    int id, at, first_at; logic err; logic [31:0] rd; bit to; exp_t e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_last = 1;
    // Tie from reset, then a lone req0, then a second tie.
    for (int round = 0; round < 3; round++) begin
      int n;
      n = (round == 1) ? 1 : 2;
      if (round == 1) begin
        drive(0, 1'b0, 32'hFFFFFA52, 32'h0);
        q.push_back(mk(0, 1'b0, shadow[18]));
      end else begin
        int w;
        w = (tb_last == 1) ? 0 : 1;
        drive(0, 1'b0, 32'hFFFFFA52, 32'h0);
        drive(1, 1'b0, 32'hFFFFFA52, 32'h0);
        q.push_back(mk(w, 1'b0, shadow[18]));
        q.push_back(mk(1 - w, 1'b0, shadow[18]));
      end
      first_at = 0;
      for (int k = 0; k < n; k++) begin
        wait_ack(8, id, err, rd, at, to);
        e = q.pop_front();
        checks++;
        if (to || id != e.id || err !== e.err || rd !== e.rdata) begin
          errors++;
          $display("FAIL tie_r%0d_%0d got to=%0b id=%0d err=%b rd=%h want id=%0d err=%b rd=%h",
                   round, k, to, id, err, rd, e.id, e.err, e.rdata);
        end
        if (k == 0) first_at = at;
        else begin
          checks++;
          if (at - first_at != 3) begin
            errors++;
            $display("FAIL tie_spacing_r%0d got %0d want 3", round, at - first_at);
          end
        end
        tb_last = e.id;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reserved;
    int id, at, w0; logic err; logic [31:0] rd; bit to; exp_t e;
    w0 = wr_count;
    drive(1, 1'b1, 32'hFFFFFA48, 32'h12345678);
    q.push_back(mk(1, 1'b1, 32'h0));
    wait_ack(8, id, err, rd, at, to);
    e = q.pop_front();
    checks++;
    if (to || id != e.id || err !== e.err || rd !== e.rdata) begin
      errors++;
      $display("FAIL reserved_ack got to=%0b id=%0d err=%b rd=%h want id=%0d err=%b rd=%h",
               to, id, err, rd, e.id, e.err, e.rdata);
    end
    checks++;
    if (wr_count != w0 || mem[8] !== shadow[8]) begin
      errors++;
      $display("FAIL reserved_nowrite got writes=%0d mem8=%h want 0 and %h", wr_count - w0, mem[8], shadow[8]);
    end
    tb_last = 1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic        err;
  } vec_t;

  task automatic test_decode;
    vec_t v[11];
    int id, at, w0, nvw; logic err; logic [31:0] rd; bit to; exp_t e;
    v[0]  = '{32'hFFFFFA40, 1'b1, 32'h40404040, 1'b0};
    v[1]  = '{32'hFFFFFA40, 1'b0, 32'h0,        1'b0};
    v[2]  = '{32'hFFFFFA42, 1'b1, 32'hBAD00002, 1'b1};
    v[3]  = '{32'hFFFFFA51, 1'b0, 32'h0,        1'b1};
    v[4]  = '{32'hFFFFFA5F, 1'b1, 32'h11112222, 1'b0};
    v[5]  = '{32'hFFFFFA5F, 1'b0, 32'h0,        1'b0};
    v[6]  = '{32'hFFFFFA60, 1'b0, 32'h0,        1'b1};
    v[7]  = '{32'h00000005, 1'b0, 32'h0,        1'b1};
    v[8]  = '{32'hFFFFFFFF, 1'b1, 32'hBAD0FFFF, 1'b1};
    v[9]  = '{32'h00000000, 1'b0, 32'h0,        1'b1};
    v[10] = '{32'hFFFFFA3F, 1'b1, 32'hBAD03F3F, 1'b1};
    w0 = wr_count;
    nvw = 0;
    for (int i = 0; i < 11; i++) begin
      int who;
      logic [4:0] off;
      who = i % 2;
      off = v[i].addr[4:0] - 5'h00;
      drive(who, v[i].we, v[i].addr, v[i].wd);
      if (!v[i].err && v[i].we) begin
        shadow[off] = v[i].wd;
        nvw++;
      end
      q.push_back(mk(who, v[i].err, (!v[i].err && !v[i].we) ? shadow[off] : 32'h0));
      wait_ack(8, id, err, rd, at, to);
      e = q.pop_front();
      checks++;
      if (to || id != e.id || err !== e.err || rd !== e.rdata) begin
        errors++;
        $display("FAIL decode_%h_we%0b got to=%0b id=%0d err=%b rd=%h want id=%0d err=%b rd=%h",
                 v[i].addr, v[i].we, to, id, err, rd, e.id, e.err, e.rdata);
      end
      @(negedge clk);
    end
    checks++;
    if (wr_count - w0 != nvw) begin
      errors++;
      $display("FAIL decode_write_count got %0d want %0d", wr_count - w0, nvw);
    end
  endtask

  task automatic test_reset_mid_access;
    logic [164:0] outs;
    int acks;
    drive(1, 1'b1, 32'hFFFFFA5F, 32'hCAFEF00D);
    @(negedge clk);
    checks++;
    if (write !== 1'b1) begin
      errors++;
      $display("FAIL midrst_access got write=%b want 1", write);
    end
    rst = 1'b1;
    #1;
    outs = {ack0, ack1, err0, err1, rdata0, rdata1, write, wrAddr, wrData, rdAddrA};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 0", outs);
    end
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    checks++;
    if (acks != 0 || mem[31] !== 32'h11112222) begin
      errors++;
      $display("FAIL midrst_effect got acks=%0d mem31=%h want 0 and 11112222", acks, mem[31]);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]    <= 32'hA0000000 | i;
      shadow[i]  = 32'hA0000000 | i;
    end
    test_reset();
    test_write_read();
    shadow[1] = 32'hDEADBEEF;
    test_tie();
    test_reserved();
    test_decode();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
